// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, {Z,N,C} condition-code register and a
// 16-iteration shift-add multiplier that stalls upstream stages while it runs.
module execute_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_NUM_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           alu_op,
  input  logic                 imm_sel,
  input  logic                 flags_en,
  input  logic                 reg_write_in,
  input  logic [REG_NUM_W-1:0] src1_num,
  input  logic [REG_NUM_W-1:0] src2_num,
  input  logic [DATA_W-1:0]    src1_value,
  input  logic [DATA_W-1:0]    src2_value,
  input  logic [DATA_W-1:0]    imm_value,
  input  logic                 em_reg_write,
  input  logic [REG_NUM_W-1:0] em_dst_num,
  input  logic [DATA_W-1:0]    em_result,
  input  logic                 mw_reg_write,
  input  logic [REG_NUM_W-1:0] mw_dst_num,
  input  logic [DATA_W-1:0]    mw_result,
  output logic [DATA_W-1:0]    result,
  output logic                 reg_write_out,
  output logic [2:0]           flags,
  output logic                 stall
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_MOV = 4'd1,  OP_ADD = 4'd2,  OP_SUB  = 4'd3,
    OP_AND  = 4'd4,  OP_OR  = 4'd5,  OP_NOT = 4'd6,  OP_INC  = 4'd7,
    OP_DEC  = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_MUL  = 4'd11,
    OP_SETC = 4'd12, OP_CLRC = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  localparam int                CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] op_a, op_b, fwd_b;
  logic [3:0]        shamt;
  logic [DATA_W:0]   add_full, sub_full, inc_full, dec_full, shl_full, shr_full;
  logic [DATA_W-1:0] alu_result;
  logic              upd_zn, upd_c, c_new;
  logic [2:0]        ccr, ccr_next;

  mul_state_e        state, state_next;
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0]  count;

  // EM is the younger producer, so it wins over MW for the same register.
  assign op_a = (em_reg_write && em_dst_num == src1_num) ? em_result :
                (mw_reg_write && mw_dst_num == src1_num) ? mw_result : src1_value;
  assign fwd_b = (em_reg_write && em_dst_num == src2_num) ? em_result :
                 (mw_reg_write && mw_dst_num == src2_num) ? mw_result : src2_value;
  assign op_b  = imm_sel ? imm_value : fwd_b;
  assign shamt = imm_value[3:0];

  // One extra bit on top catches carry/borrow; for shifts it catches the last bit out.
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} - {1'b0, op_b};
  assign inc_full = {1'b0, op_a} + (DATA_W + 1)'(1);
  assign dec_full = {1'b0, op_a} - (DATA_W + 1)'(1);
  assign shl_full = {1'b0, op_a} << shamt;
  assign shr_full = {op_a, 1'b0} >> shamt;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    alu_result = '0;
    upd_zn     = 1'b0;
    upd_c      = 1'b0;
    c_new      = 1'b0;
    case (alu_op)
      OP_NOP:  ;
      OP_MOV:  begin alu_result = op_a;                upd_zn = 1'b1; end
      OP_ADD:  begin alu_result = add_full[DATA_W-1:0]; c_new = add_full[DATA_W];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_SUB:  begin alu_result = sub_full[DATA_W-1:0]; c_new = sub_full[DATA_W];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_AND:  begin alu_result = op_a & op_b;         upd_zn = 1'b1; end
      OP_OR:   begin alu_result = op_a | op_b;         upd_zn = 1'b1; end
      OP_NOT:  begin alu_result = ~op_a;               upd_zn = 1'b1; end
      OP_INC:  begin alu_result = inc_full[DATA_W-1:0]; c_new = inc_full[DATA_W];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_DEC:  begin alu_result = dec_full[DATA_W-1:0]; c_new = dec_full[DATA_W];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_SHL:  begin alu_result = shl_full[DATA_W-1:0]; c_new = shl_full[DATA_W];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_SHR:  begin alu_result = shr_full[DATA_W:1];   c_new = shr_full[0];
                     upd_zn = 1'b1; upd_c = 1'b1; end
      OP_MUL:  begin alu_result = acc;                 upd_zn = 1'b1; end
      OP_SETC: begin c_new = 1'b1;                     upd_c = 1'b1; end
      OP_CLRC: begin                                   upd_c = 1'b1; end
      default: alu_result = op_a;
    endcase
  end

  assign ccr_next = {upd_zn ? (alu_result == '0)      : ccr[2],
                     upd_zn ? alu_result[DATA_W-1]    : ccr[1],
                     upd_c  ? c_new                   : ccr[0]};

  // A pending multiply holds the pipeline until its DONE cycle.
  assign stall         = (alu_op == OP_MUL) && (state != DONE);
  assign reg_write_out = reg_write_in & ~stall;
  assign result        = alu_result;
  assign flags         = ccr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) ccr <= 3'b000;
    else if (flags_en && !stall) ccr <= ccr_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (alu_op == OP_MUL) state_next = BUSY;
      BUSY:    if (count == LAST_ITER) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (alu_op == OP_MUL) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          count  <= '0;
        end
        BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized ops
// checked against an arithmetic reference model of the ALU, CCR and MUL timing.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_op;
  logic        imm_sel, flags_en, reg_write_in;
  logic [2:0]  src1_num, src2_num;
  logic [15:0] src1_value, src2_value, imm_value;
  logic        em_reg_write, mw_reg_write;
  logic [2:0]  em_dst_num, mw_dst_num;
  logic [15:0] em_result, mw_result;
  logic [15:0] result;
  logic        reg_write_out, stall;
  logic [2:0]  flags;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  m_ccr;

  execute_stage #(.DATA_W(16), .REG_NUM_W(3)) dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .imm_sel(imm_sel),
    .flags_en(flags_en), .reg_write_in(reg_write_in),
    .src1_num(src1_num), .src2_num(src2_num),
    .src1_value(src1_value), .src2_value(src2_value), .imm_value(imm_value),
    .em_reg_write(em_reg_write), .em_dst_num(em_dst_num), .em_result(em_result),
    .mw_reg_write(mw_reg_write), .mw_dst_num(mw_dst_num), .mw_result(mw_result),
    .result(result), .reg_write_out(reg_write_out), .flags(flags), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [2:0] num, input logic [15:0] val);
    if (em_reg_write && em_dst_num == num) return em_result;
    if (mw_reg_write && mw_dst_num == num) return mw_result;
    return val;
  endfunction

  // Reference ALU: plain integer arithmetic on the operation table.
  task automatic ref_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int unsigned sh, input logic [2:0] ccr_in,
                          output logic [15:0] res, output logic [2:0] ccr_out);
    int unsigned ua, ub, r;
    bit zn, cu, c;
    ua = a; ub = b; r = 0; zn = 0; cu = 0; c = 0;
    case (op)
      4'd0:  r = 0;
      4'd1:  begin r = ua;      zn = 1; end
      4'd2:  begin r = ua + ub; c = (r > 32'hFFFF); zn = 1; cu = 1; end
      4'd3:  begin r = ua - ub; c = (ua < ub);      zn = 1; cu = 1; end
      4'd4:  begin r = ua & ub; zn = 1; end
      4'd5:  begin r = ua | ub; zn = 1; end
      4'd6:  begin r = ~ua;     zn = 1; end
      4'd7:  begin r = ua + 1;  c = (ua == 32'hFFFF); zn = 1; cu = 1; end
      4'd8:  begin r = ua - 1;  c = (ua == 0);        zn = 1; cu = 1; end
      4'd9:  begin r = ua << sh; c = (sh != 0) ? ((ua >> (16 - sh)) & 1) != 0 : 0;
                   zn = 1; cu = 1; end
      4'd10: begin r = ua >> sh; c = (sh != 0) ? ((ua >> (sh - 1)) & 1) != 0 : 0;
                   zn = 1; cu = 1; end
      4'd11: begin r = ua * ub; zn = 1; end
      4'd12: begin c = 1; cu = 1; end
      4'd13: begin c = 0; cu = 1; end
      default: r = ua;
    endcase
    res = r[15:0];
    ccr_out = ccr_in;
    if (zn) begin ccr_out[2] = (res == 16'h0000); ccr_out[1] = res[15]; end
    if (cu) ccr_out[0] = c;
  endtask

  // Entered and left just after a rising edge; outputs sampled on the falling edge.
  task automatic issue(input logic [3:0] op, input logic isel, input logic fen,
                       input logic rw, output logic [15:0] got_res,
                       output logic [2:0] got_flags);
    logic [15:0] a, b, exp_res;
    logic [2:0]  exp_ccr;
    int n, rw_cycles;
    alu_op = op; imm_sel = isel; flags_en = fen; reg_write_in = rw;
    a = fwd(src1_num, src1_value);
    b = isel ? imm_value : fwd(src2_num, src2_value);
    ref_exec(op, a, b, int'(imm_value[3:0]), m_ccr, exp_res, exp_ccr);
    @(negedge clk);
    if (op == 4'd11) begin
      n = 0; rw_cycles = 0;
      while (stall === 1'b1 && n < 40) begin
        if (reg_write_out) rw_cycles++;
        n++;
        @(negedge clk);
      end
      check("mul_stall_cycles", n, 17);
      check("mul_rw_during_stall", rw_cycles, 0);
    end else begin
      check("stall", {31'b0, stall}, 0);
    end
    check("reg_write_out", {31'b0, reg_write_out}, {31'b0, rw});
    got_res = result;
    if (op != 4'd12 && op != 4'd13) check("result", {16'b0, result}, {16'b0, exp_res});
    @(posedge clk); #1;
    if (fen) m_ccr = exp_ccr;
    got_flags = flags;
    check("flags", {29'b0, flags}, {29'b0, m_ccr});
    alu_op = 4'd0;
  endtask

  task automatic set_operands(input logic [2:0] s1n, input logic [15:0] s1v,
                              input logic [2:0] s2n, input logic [15:0] s2v,
                              input logic [15:0] imm);
    src1_num = s1n; src1_value = s1v; src2_num = s2n; src2_value = s2v; imm_value = imm;
    em_reg_write = 0; em_dst_num = 0; em_result = 0;
    mw_reg_write = 0; mw_dst_num = 0; mw_result = 0;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] r;
    logic [2:0]  f;
    logic [3:0]  op;

    reset = 1'b0; alu_op = 0; imm_sel = 0; flags_en = 0; reg_write_in = 0;
    set_operands(0, 0, 0, 0, 0);
    m_ccr = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {29'b0, flags}, 0);
    @(negedge clk);
    check("reset_stall", {31'b0, stall}, 0);
    check("reset_result", {16'b0, result}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // ADD with EM hazard on src1
    set_operands(3'd1, 16'h0005, 3'd0, 16'h0000, 16'h0003);
    em_reg_write = 1; em_dst_num = 3'd1; em_result = 16'h0010;
    issue(4'd2, 1'b1, 1'b1, 1'b1, r, f);
    check("add_em_result", {16'b0, r}, 32'h0013);
    check("add_em_flags", {29'b0, f}, 32'h0);

    // EM beats MW on src2
    set_operands(3'd3, 16'h0001, 3'd2, 16'h7777, 16'h0000);
    em_reg_write = 1; em_dst_num = 3'd2; em_result = 16'h0001;
    mw_reg_write = 1; mw_dst_num = 3'd2; mw_result = 16'h0002;
    issue(4'd3, 1'b0, 1'b1, 1'b1, r, f);
    check("prio_result", {16'b0, r}, 32'h0000);
    check("prio_flags", {29'b0, f}, 32'h4);

    // SUB borrow, then the same kind of op with flags disabled
    set_operands(3'd1, 16'h0002, 3'd0, 16'h0000, 16'h0005);
    issue(4'd3, 1'b1, 1'b1, 1'b1, r, f);
    check("sub_borrow_result", {16'b0, r}, 32'hFFFD);
    check("sub_borrow_flags", {29'b0, f}, 32'h3);
    set_operands(3'd1, 16'h0005, 3'd0, 16'h0000, 16'h0002);
    issue(4'd3, 1'b1, 1'b0, 1'b1, r, f);
    check("sub_noflags", {29'b0, f}, 32'h3);

    // MUL 300 x 7, C retained
    set_operands(3'd1, 16'd300, 3'd0, 16'h0000, 16'd7);
    issue(4'd11, 1'b1, 1'b1, 1'b1, r, f);
    check("mul_300x7", {16'b0, r}, 32'h0834);
    check("mul_300x7_flags", {29'b0, f}, 32'h1);

    // MUL overflow
    set_operands(3'd1, 16'h0100, 3'd2, 16'h0100, 16'h0000);
    issue(4'd11, 1'b0, 1'b1, 1'b1, r, f);
    check("mul_ovf", {16'b0, r}, 32'h0000);
    check("mul_ovf_flags", {29'b0, f}, 32'h5);

    // SHL 0x8001 by 1
    set_operands(3'd1, 16'h8001, 3'd0, 16'h0000, 16'h0001);
    issue(4'd9, 1'b1, 1'b1, 1'b1, r, f);
    check("shl_result", {16'b0, r}, 32'h0002);
    check("shl_flags", {29'b0, f}, 32'h1);

    // Reset in the 8th BUSY cycle aborts the multiply
    issue(4'd12, 1'b0, 1'b1, 1'b0, r, f);
    set_operands(3'd1, 16'd300, 3'd0, 16'h0000, 16'd7);
    alu_op = 4'd11; imm_sel = 1; flags_en = 1; reg_write_in = 1;
    @(posedge clk); #1;
    repeat (7) @(posedge clk);
    #1;
    check("busy_stall", {31'b0, stall}, 1);
    reset = 1'b0; alu_op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_ccr = 3'b000;
    check("abort_stall", {31'b0, stall}, 0);
    check("abort_flags", {29'b0, flags}, 0);
    issue(4'd11, 1'b1, 1'b1, 1'b1, r, f);
    check("reissue_mul", {16'b0, r}, 32'h0834);

    // Randomized operations with random forwarding hits
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      src1_num = 3'($urandom_range(0, 3)); src2_num = 3'($urandom_range(0, 3));
      src1_value = rnd16(); src2_value = rnd16(); imm_value = rnd16();
      em_reg_write = 1'($urandom); em_dst_num = 3'($urandom_range(0, 3)); em_result = rnd16();
      mw_reg_write = 1'($urandom); mw_dst_num = 3'($urandom_range(0, 3)); mw_result = rnd16();
      issue(op, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), r, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
